// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and
// owner-index width helpers.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NREQ_DEF = 4;
  localparam int OWNER_W  = owner_w(NREQ_DEF);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: finds the first set request at or above
// 'start', wrapping past NREQ-1 back to 0.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OW   = owner_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   start,
  output logic [OW-1:0]   idx,
  output logic            vld
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [OW:0]       sum;

  // Rotate requests so bit 0 is 'start', then take the lowest set bit;
  // scanning downward lets the nearest candidate win the last assignment.
  always_comb begin
    dbl = {req, req};
    rot = NREQ'(dbl >> start);
    idx = '0;
    vld = 1'b0;
    sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, start} + (OW + 1)'(k);
        if (sum >= (OW + 1)'(NREQ)) begin
          sum = sum - (OW + 1)'(NREQ);
        end
        idx = sum[OW-1:0];
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NREQ requesters.
// Each grant is a burst of up to BURST_MAX accepted words; FIFO full stalls
// the burst without consuming its word budget.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  input  logic                    fifo_f,
  output logic                    fifo_in_ready,
  output logic [WIDTH-1:0]        fifo_data_in,
  output logic [owner_w(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int OW   = owner_w(NREQ);
  localparam int BC_W = $clog2(BURST_MAX) + 1;

  localparam logic [OW-1:0]   LAST_IDX  = OW'(NREQ - 1);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BURST_MAX - 1);

  state_t          state;
  logic [BC_W-1:0] beat_cnt;
  logic [OW-1:0]   start_idx;
  logic [OW-1:0]   pick_idx;
  logic            pick_vld;
  logic            own_req;
  logic            accept;

  // Search begins just past the previous owner so every requester gets a turn.
  assign start_idx = (owner == LAST_IDX) ? '0 : owner + OW'(1);

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_rr_pick (
    .req   (req),
    .start (start_idx),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  assign own_req = req[owner];
  assign accept  = (state == BURST) && own_req && !fifo_f;
  assign busy    = (state == BURST);

  // Grant only the owner, and only when the FIFO can take the word.
  always_comb begin
    gnt        = '0;
    gnt[owner] = accept;
  end

  assign fifo_in_ready = |gnt;
  assign fifo_data_in  = req_data[owner*WIDTH +: WIDTH];

  // Arbitration FSM: IDLE picks the next owner, BURST counts accepted words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner    <= LAST_IDX;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner    <= pick_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (!own_req) begin
            state <= IDLE;
          end else if (!fifo_f) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + BC_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural FIFO (depth 8) and
// requesters that advance their data word after every grant.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int BURST_MAX = 4;
  localparam int DEPTH     = 8;
  localparam int OW        = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_f;
  logic                  fifo_in_ready;
  logic [WIDTH-1:0]      fifo_data_in;
  logic [OW-1:0]         owner;
  logic                  busy;

  logic [NREQ-1:0] en;
  int              lim [NREQ];
  int              wcnt [NREQ];
  logic [WIDTH-1:0] mem [64];
  int              nwr, nrd;
  logic            bp_en, rd, mdl_clr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .fifo_f        (fifo_f),
    .fifo_in_ready (fifo_in_ready),
    .fifo_data_in  (fifo_data_in),
    .owner         (owner),
    .busy          (busy)
  );

  // Requester i offers word i*16 + (words already accepted); it drops req
  // once it has delivered lim[i] words (lim < 0 means unlimited).
  always_comb begin
    req      = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = en[i] && (lim[i] < 0 || wcnt[i] < lim[i]);
      req_data[i*WIDTH +: WIDTH] = WIDTH'(i * 16 + wcnt[i]);
    end
  end

  assign fifo_f = bp_en && ((nwr - nrd) >= DEPTH);

  always @(posedge clk) begin
    if (mdl_clr) begin
      for (int i = 0; i < NREQ; i++) wcnt[i] <= 0;
      nwr <= 0;
      nrd <= 0;
    end else begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) wcnt[i] <= wcnt[i] + 1;
      if (fifo_in_ready) begin
        mem[nwr[5:0]] <= fifo_data_in;
        nwr <= nwr + 1;
      end
      if (rd && (nwr - nrd) > 0) nrd <= nrd + 1;
    end
  end

  task automatic hold_reset();
    @(negedge clk);
    reset_n = 1'b0;
    mdl_clr = 1'b1;
    bp_en   = 1'b0;
    rd      = 1'b0;
    en      = '0;
    for (int i = 0; i < NREQ; i++) lim[i] = -1;
    @(negedge clk);
    mdl_clr = 1'b0;
  endtask

  task automatic test_reset();
    hold_reset();
    en = 4'b1111;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++; if (owner !== 2'd2) begin n_bad++; $display("FAIL rst_pre_owner: got %0d want 2", owner); end
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL rst_pre_gnt: got %b want 0100", gnt); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    n_cmp++; if (fifo_in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", fifo_in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (owner !== 2'd3) begin n_bad++; $display("FAIL rst_owner: got %0d want 3", owner); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_rel_gnt: got %b want 0000", gnt); end
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rst_first_gnt: got %b want 0001", gnt); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL rst_first_owner: got %0d want 0", owner); end
  endtask

  task automatic test_single_burst();
    logic [NREQ-1:0] exp_gnt [9];
    exp_gnt = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0010};
    hold_reset();
    en = 4'b0010;
    reset_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt !== exp_gnt[c]) begin n_bad++; $display("FAIL single_gnt[c%0d]: got %b want %b", c + 1, gnt, exp_gnt[c]); end
      n_cmp++; if (fifo_in_ready !== (|exp_gnt[c])) begin n_bad++; $display("FAIL single_ready[c%0d]: got %b want %b", c + 1, fifo_in_ready, |exp_gnt[c]); end
    end
    @(negedge clk);
    en = '0;
    n_cmp++; if (nwr !== 8) begin n_bad++; $display("FAIL single_nwr: got %0d want 8", nwr); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (mem[k] !== WIDTH'(8'h10 + k)) begin n_bad++; $display("FAIL single_data[%0d]: got %h want %h", k, mem[k], 8'h10 + k); end
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] eg;
    hold_reset();
    en = 4'b1111;
    reset_n = 1'b1;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      eg = (c % 5 == 4) ? 4'b0000 : NREQ'(1 << ((c / 5) % 4));
      n_cmp++; if (gnt !== eg) begin n_bad++; $display("FAIL rr_gnt[c%0d]: got %b want %b", c + 1, gnt, eg); end
      if (c % 5 != 4) begin
        n_cmp++; if (owner !== OW'((c / 5) % 4)) begin n_bad++; $display("FAIL rr_owner[c%0d]: got %0d want %0d", c + 1, owner, (c / 5) % 4); end
      end
    end
  endtask

  task automatic test_early_drop();
    logic [NREQ-1:0] exp_gnt [9];
    exp_gnt = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000,
                4'b1000, 4'b1000, 4'b1000, 4'b0000};
    hold_reset();
    en = 4'b1100;
    lim[2] = 2;
    reset_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt !== exp_gnt[c]) begin n_bad++; $display("FAIL drop_gnt[c%0d]: got %b want %b", c + 1, gnt, exp_gnt[c]); end
      if (c == 2) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drop_busy_c3: got %b want 1", busy); end
      end
      if (c == 3) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy_c4: got %b want 0", busy); end
      end
    end
    n_cmp++; if (nwr !== 6) begin n_bad++; $display("FAIL drop_nwr: got %0d want 6", nwr); end
    n_cmp++; if (mem[1] !== 8'h21) begin n_bad++; $display("FAIL drop_data1: got %h want 21", mem[1]); end
    n_cmp++; if (mem[2] !== 8'h30) begin n_bad++; $display("FAIL drop_data2: got %h want 30", mem[2]); end
  endtask

  task automatic test_back_pressure();
    logic [NREQ-1:0] exp_tail [4];
    exp_tail = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
    hold_reset();
    bp_en = 1'b1;
    en = 4'b1111;
    reset_n = 1'b1;
    repeat (11) @(negedge clk);
    for (int c = 11; c <= 14; c++) begin
      n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL bp_full_gnt[c%0d]: got %b want 0000", c, gnt); end
      n_cmp++; if (busy !== 1'b1 || owner !== 2'd2) begin n_bad++; $display("FAIL bp_full_state[c%0d]: got busy=%b owner=%0d want busy=1 owner=2", c, busy, owner); end
      if (c < 14) @(negedge clk);
    end
    n_cmp++; if (nwr !== 8) begin n_bad++; $display("FAIL bp_nwr8: got %0d want 8", nwr); end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL bp_after_read_gnt: got %b want 0100", gnt); end
    n_cmp++; if (fifo_data_in !== 8'h20) begin n_bad++; $display("FAIL bp_after_read_data: got %h want 20", fifo_data_in); end
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL bp_refull_gnt: got %b want 0000", gnt); end
    n_cmp++; if (nwr !== 9) begin n_bad++; $display("FAIL bp_nwr9: got %0d want 9", nwr); end
    n_cmp++; if (mem[8] !== 8'h20) begin n_bad++; $display("FAIL bp_data8: got %h want 20", mem[8]); end
    rd = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt !== exp_tail[c]) begin n_bad++; $display("FAIL bp_tail_gnt[%0d]: got %b want %b", c, gnt, exp_tail[c]); end
    end
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL bp_next_owner_gnt: got %b want 1000", gnt); end
    rd = 1'b0;
    bp_en = 1'b0;
  endtask

  task automatic test_wrap_around();
    hold_reset();
    en = 4'b1000;
    lim[3] = 4;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL wrap_g3[c%0d]: got %b want 1000", c + 1, gnt); end
    end
    en = 4'b1101;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || owner !== 2'd3) begin n_bad++; $display("FAIL wrap_idle: got busy=%b owner=%0d want busy=0 owner=3", busy, owner); end
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_gnt: got %b want 0001", gnt); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL wrap_owner: got %0d want 0", owner); end
  endtask

  initial begin
    reset_n = 1'b0;
    mdl_clr = 1'b1;
    bp_en   = 1'b0;
    rd      = 1'b0;
    en      = '0;
    for (int i = 0; i < NREQ; i++) lim[i] = -1;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_early_drop();
    test_back_pressure();
    test_wrap_around();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
